// File: rtl/uart_pkg.sv
// Shared constants, divisor type and divisor helper for the UART baud generator.
package uart_pkg;

  localparam int unsigned UART_DIV_W       = 16;
  localparam int unsigned UART_OVERSAMPLE  = 16;
  localparam int unsigned UART_DEFAULT_DIV = 100;
  localparam int unsigned UART_FRAC_W      = 4;

  typedef logic [UART_DIV_W-1:0] uart_div_t;

  // Rounded divisor clk_hz / (baud * oversample); 0 if the denominator is 0.
  function automatic uart_div_t uart_calc_div(input int unsigned clk_hz,
                                              input int unsigned baud,
                                              input int unsigned oversample);
    logic [63:0] den;
    logic [63:0] quo;
    den = 64'(baud) * 64'(oversample);
    if (den == 64'd0) begin
      quo = 64'd0;
    end else begin
      quo = (64'(clk_hz) + (den >> 1)) / den;
    end
    return uart_div_t'(quo);
  endfunction

endpackage

// File: rtl/uart_mod_counter.sv
// Modulo-N counter with sync clear and a combinational terminal-count pulse.
// modulus==0 stalls the counter at its current value (held at 0 after a clear).
module uart_mod_counter
  import uart_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] modulus,
  output logic         tc_c
);

  logic [W-1:0] cnt;
  logic         at_end_c;

  // >= keeps the counter bounded even if the modulus shrinks mid-count.
  assign at_end_c = (modulus != '0) && (cnt >= (modulus - W'(1)));
  assign tc_c     = en && !clr && at_end_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (modulus != '0)) begin
      cnt <= at_end_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_tick_gen.sv
// Programmable baud generator: clk / div_q -> os_tick, / OVERSAMPLE -> baud_tick, baud_clk.
// Optional fractional divisor enabled by defining UART_BAUD_FRAC_EN.
module uart_baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W       = UART_DIV_W,
  parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
`ifdef UART_BAUD_FRAC_EN
  parameter int unsigned FRAC_W      = UART_FRAC_W,
`endif
  parameter int unsigned DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
`ifdef UART_BAUD_FRAC_EN
  input  logic [FRAC_W-1:0] frac_in,
`endif
  output logic [DIV_W-1:0] div_q,
  output logic             os_tick,
  output logic             baud_tick,
  output logic             baud_clk
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE + 1);
`ifdef UART_BAUD_FRAC_EN
  localparam int unsigned PRE_W = DIV_W + 1;
`else
  localparam int unsigned PRE_W = DIV_W;
`endif

  logic             run_clr_c;
  logic             pre_tc_c;
  logic             os_tc_c;
  logic [PRE_W-1:0] pre_mod_c;

  // A load or a disable restarts the whole divider chain from zero.
  assign run_clr_c = div_load | ~en;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_q;
  logic [FRAC_W-1:0] frac_acc;
  logic              stretch;
  logic [FRAC_W:0]   frac_sum_c;

  assign frac_sum_c = {1'b0, frac_acc} + {1'b0, frac_q};
  assign pre_mod_c  = PRE_W'(div_q) + PRE_W'(stretch);

  // Accumulator carry lengthens the following prescale period by one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_q   <= '0;
      frac_acc <= '0;
      stretch  <= 1'b0;
    end else begin
      if (div_load) begin
        frac_q <= frac_in;
      end
      if (run_clr_c) begin
        frac_acc <= '0;
        stretch  <= 1'b0;
      end else if (pre_tc_c) begin
        frac_acc <= frac_sum_c[FRAC_W-1:0];
        stretch  <= frac_sum_c[FRAC_W];
      end
    end
  end
`else
  assign pre_mod_c = div_q;
`endif

  uart_mod_counter #(.W(PRE_W)) u_pre_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (run_clr_c),
    .en      (en),
    .modulus (pre_mod_c),
    .tc_c    (pre_tc_c)
  );

  uart_mod_counter #(.W(OS_W)) u_os_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (run_clr_c),
    .en      (pre_tc_c),
    .modulus (OS_W'(OVERSAMPLE)),
    .tc_c    (os_tc_c)
  );

  // Registered strobes and square wave; div_load already masks the wrap pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= DIV_W'(DEFAULT_DIV);
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      baud_clk  <= 1'b0;
    end else begin
      if (div_load) begin
        div_q <= div_in;
      end
      os_tick   <= pre_tc_c;
      baud_tick <= os_tc_c;
      if (!en) begin
        baud_clk <= 1'b0;
      end else if (os_tc_c) begin
        baud_clk <= ~baud_clk;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Randomised + directed bench for uart_baud_tick_gen against a timestamp-based reference.
module tb_uart_baud_tick_gen;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned OS     = 16;
  localparam int unsigned FRAC_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [DIV_W-1:0] div_in;
  logic             div_load;
  logic [FRAC_W-1:0] frac_in;
  logic [DIV_W-1:0] div_q;
  logic             os_tick;
  logic             baud_tick;
  logic             baud_clk;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_baud_tick_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div_in    (div_in),
    .div_load  (div_load),
`ifdef UART_BAUD_FRAC_EN
    .frac_in   (frac_in),
`endif
    .div_q     (div_q),
    .os_tick   (os_tick),
    .baud_tick (baud_tick),
    .baud_clk  (baud_clk)
  );

  // Reference: absolute edge number of the next expected os_tick.
  longint cyc;
  longint next_os;
  int     nos;
  int     m_div;
  int     m_frac;
  int     m_acc;
  logic   m_bclk;
  logic   e_os;
  logic   e_baud;
  int     os_seen;
  int     baud_seen;
  longint os_edges[$];
  longint baud_edges[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_restart();
    nos     = 0;
    m_acc   = 0;
    next_os = (m_div == 0) ? -1 : cyc + longint'(m_div);
  endtask

  task automatic model_reset();
    cyc    = 0;
    m_div  = 100;
    m_frac = 0;
    m_bclk = 1'b0;
    model_restart();
  endtask

  task automatic step();
    int carry;
    @(posedge clk);
    cyc++;
    e_os   = 1'b0;
    e_baud = 1'b0;
    if (div_load) begin
      m_div  = int'(div_in);
      m_frac = int'(frac_in);
      if (!en) m_bclk = 1'b0;
      model_restart();
    end else if (!en) begin
      m_bclk = 1'b0;
      model_restart();
    end else if (cyc == next_os) begin
      e_os = 1'b1;
      nos++;
      if (nos % OS == 0) begin
        e_baud = 1'b1;
        m_bclk = ~m_bclk;
      end
      m_acc  += m_frac;
      carry   = m_acc >> FRAC_W;
      m_acc   = m_acc % (1 << FRAC_W);
      next_os = cyc + longint'(m_div + carry);
    end
    #1;
    check_eq("os_tick", 32'(os_tick), 32'(e_os));
    check_eq("baud_tick", 32'(baud_tick), 32'(e_baud));
    check_eq("baud_clk", 32'(baud_clk), 32'(m_bclk));
    check_eq("div_q", 32'(div_q), 32'(m_div));
    os_seen   += int'(os_tick);
    baud_seen += int'(baud_tick);
    if (os_tick) os_edges.push_back(cyc);
    if (baud_tick) baud_edges.push_back(cyc);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load(input int d);
    div_in   = DIV_W'(d);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    os_seen   = 0;
    baud_seen = 0;
    os_edges.delete();
    baud_edges.delete();
  endtask

  longint t_off;

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    div_load = 1'b0;
    div_in   = '0;
    frac_in  = '0;
    model_reset();
    #12;
    check_eq("rst_div_q", 32'(div_q), 32'd100);
    check_eq("rst_os_tick", 32'(os_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default divisor from reset: os every 100, baud at 1600 and 3200.
    clear_log();
    run(3300);
    check_eq("t2_os_count", 32'(os_seen), 32'd33);
    check_eq("t2_baud_count", 32'(baud_seen), 32'd2);
    check_eq("t2_first_os", (os_edges.size() > 0) ? 32'(os_edges[0]) : 32'hFFFF_FFFF, 32'd100);
    check_eq("t2_first_baud", (baud_edges.size() > 0) ? 32'(baud_edges[0]) : 32'hFFFF_FFFF, 32'd1600);

    // Runtime load at edge 250.
    sync_reset();
    run(249);
    clear_log();
    load(4);
    check_eq("t3_load_no_tick", 32'(os_tick), 32'd0);
    run(100);
    check_eq("t3_first_os", (os_edges.size() > 0) ? 32'(os_edges[0]) : 32'hFFFF_FFFF, 32'd254);
    check_eq("t3_second_os", (os_edges.size() > 1) ? 32'(os_edges[1]) : 32'hFFFF_FFFF, 32'd258);
    check_eq("t3_first_baud", (baud_edges.size() > 0) ? 32'(baud_edges[0]) : 32'hFFFF_FFFF, 32'd314);

    // Divisor 1 and 0 boundaries, then a load landing on a wrap edge.
    load(1);
    clear_log();
    run(64);
    check_eq("t4_div1_os", 32'(os_seen), 32'd64);
    check_eq("t4_div1_baud", 32'(baud_seen), 32'd4);
    load(0);
    clear_log();
    run(1000);
    check_eq("t4_div0_os", 32'(os_seen), 32'd0);
    check_eq("t4_div0_baud", 32'(baud_seen), 32'd0);
    load(5);
    run(7);
    for (int i = 0; i < 10 && next_os != cyc + 1; i++) step();
    load(5);
    check_eq("t4_load_on_wrap", 32'(os_tick), 32'd0);
    run(20);

    // Enable dropped mid-period.
    load(20);
    run(33);
    en = 1'b0;
    run(5);
    check_eq("t5_off_bclk", 32'(baud_clk), 32'd0);
    t_off = cyc;
    en = 1'b1;
    clear_log();
    run(25);
    check_eq("t5_reenable_os", (os_edges.size() > 0) ? 32'(os_edges[0]) : 32'hFFFF_FFFF, 32'(t_off + 20));

    // Async reset mid-count with a non-default divisor loaded.
    load(7);
    run(130);
    check_eq("t1_pre_bclk", 32'(baud_clk), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t1_async_div_q", 32'(div_q), 32'd100);
    check_eq("t1_async_bclk", 32'(baud_clk), 32'd0);
    check_eq("t1_async_os", 32'(os_tick), 32'd0);
    check_eq("t1_async_baud", 32'(baud_tick), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(150);

`ifdef UART_BAUD_FRAC_EN
    // Fractional divisor 10 + 8/16: steady periods alternate 10 and 11.
    frac_in = FRAC_W'(8);
    load(10);
    clear_log();
    run(200);
    check_eq("t6_frac_16_periods",
             (os_edges.size() > 16) ? 32'(os_edges[16] - os_edges[0]) : 32'hFFFF_FFFF, 32'd168);
`endif

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      en       = ($urandom_range(0, 99) < 97);
      div_load = ($urandom_range(0, 99) < 3);
      div_in   = DIV_W'($urandom_range(0, 12));
`ifdef UART_BAUD_FRAC_EN
      frac_in  = FRAC_W'($urandom_range(0, 15));
`endif
      step();
    end
    div_load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
